// File: rtl/physical_tx_skp_inserter_if.sv
// Encoder-to-inserter word stream: 8b10b word, valid, running disparity and ready.
interface physical_tx_skp_inserter_if;
  logic [9:0] data;
  logic       valid;
  logic       rd;
  logic       ready;

  modport master (output data, output valid, output rd, input ready);
  modport slave  (input data, input valid, input rd, output ready);
endinterface

// File: rtl/physical_tx_skp_inserter.sv
// Transmit word source for the 10-bit serializer: SKP training pattern after start,
// then encoded data with periodic and underflow-triggered disparity-neutral SKP bursts.
module physical_tx_skp_inserter #(
  parameter int TRAIN_CYCLES = 1024,
  parameter int SKP_INTERVAL = 256,
  parameter int SKP_BURST    = 2
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic                             start,
  physical_tx_skp_inserter_if.slave        enc,
  output logic [9:0]                       tx_data,
  output logic                             training,
  output logic                             train_done,
  output logic                             skp_active
);

  localparam int TW = $clog2(TRAIN_CYCLES + 1);
  localparam int IW = $clog2(SKP_INTERVAL);
  localparam int BW = $clog2(SKP_BURST);
  localparam logic [9:0]    SKP_NEG    = 10'h33c;
  localparam logic [9:0]    SKP_POS    = 10'h0c3;
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_CYCLES);
  localparam logic [IW-1:0] INT_LAST   = IW'(SKP_INTERVAL - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(SKP_BURST - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_DATA, ST_SKP} state_t;

  logic [1:0]    rst_sync_reg;
  logic          rst_n;
  state_t        state_reg, state_next;
  logic [TW-1:0] train_cnt_reg, train_cnt_next;
  logic [IW-1:0] int_cnt_reg, int_cnt_next;
  logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
  logic          skp_rd_reg, skp_rd_next;
  logic          idle_phase_reg, idle_phase_next;
  logic [9:0]    data_reg, data_next;
  logic          skp_active_reg, skp_active_next;
  logic          train_done_reg, train_done_next;
  logic          start_reg;
  logic          start_flag;

  // Local reset: asserts immediately, releases two clocks after arst_n rises.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rst_sync_reg <= 2'b00;
    else         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  assign start_flag = start & ~start_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start_flag) begin
      state_next = ST_TRAIN;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_IDLE;
        ST_TRAIN: if (train_cnt_reg == TRAIN_LAST) state_next = ST_DATA;
        ST_DATA:  if (!enc.valid || int_cnt_reg == INT_LAST) state_next = ST_SKP;
        ST_SKP:   if (burst_cnt_reg == BURST_LAST) state_next = ST_DATA;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // SKP words lag the SKP state by one cycle so the last accepted word still goes out first.
  always_comb begin
    data_next       = data_reg;
    skp_active_next = 1'b0;
    train_done_next = train_done_reg;
    train_cnt_next  = train_cnt_reg;
    int_cnt_next    = int_cnt_reg;
    burst_cnt_next  = burst_cnt_reg;
    skp_rd_next     = skp_rd_reg;
    idle_phase_next = idle_phase_reg;
    if (start_flag) begin
      data_next       = SKP_NEG;
      train_done_next = 1'b0;
      train_cnt_next  = TW'(1);
      int_cnt_next    = '0;
      burst_cnt_next  = '0;
      idle_phase_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          data_next       = idle_phase_reg ? SKP_POS : SKP_NEG;
          idle_phase_next = ~idle_phase_reg;
        end
        ST_TRAIN: begin
          if (train_cnt_reg == TRAIN_LAST) begin
            train_done_next = 1'b1;
            train_cnt_next  = '0;
          end else begin
            data_next      = train_cnt_reg[0] ? SKP_POS : SKP_NEG;
            train_cnt_next = train_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (enc.valid) begin
            data_next    = enc.data;
            int_cnt_next = (int_cnt_reg == INT_LAST) ? '0 : int_cnt_reg + 1'b1;
          end
          if (!enc.valid || int_cnt_reg == INT_LAST) begin
            skp_rd_next    = enc.rd;
            burst_cnt_next = '0;
          end
        end
        ST_SKP: begin
          data_next       = (skp_rd_reg ^ burst_cnt_reg[0]) ? SKP_POS : SKP_NEG;
          skp_active_next = 1'b1;
          if (burst_cnt_reg == BURST_LAST) begin
            burst_cnt_next = '0;
            int_cnt_next   = '0;
          end else begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end
        end
        default: data_next = data_reg;
      endcase
    end
  end

  // start_reg resets high so a start level held through reset is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg       <= '0;
      skp_active_reg <= 1'b0;
      train_done_reg <= 1'b0;
      train_cnt_reg  <= '0;
      int_cnt_reg    <= '0;
      burst_cnt_reg  <= '0;
      skp_rd_reg     <= 1'b0;
      idle_phase_reg <= 1'b0;
      start_reg      <= 1'b1;
    end else begin
      data_reg       <= data_next;
      skp_active_reg <= skp_active_next;
      train_done_reg <= train_done_next;
      train_cnt_reg  <= train_cnt_next;
      int_cnt_reg    <= int_cnt_next;
      burst_cnt_reg  <= burst_cnt_next;
      skp_rd_reg     <= skp_rd_next;
      idle_phase_reg <= idle_phase_next;
      start_reg      <= start;
    end
  end

  assign enc.ready  = (state_reg == ST_DATA);
  assign training   = (state_reg == ST_TRAIN);
  assign tx_data    = data_reg;
  assign skp_active = skp_active_reg;
  assign train_done = train_done_reg;

endmodule

// File: tb/tb_physical_tx_skp_inserter.sv
// Bench for physical_tx_skp_inserter: expected output words queued as stimulus is
// driven, popped and compared one cycle later.
`timescale 1ns/1ps
module tb_physical_tx_skp_inserter;
  localparam logic [9:0] SKP_NEG  = 10'h33c;
  localparam logic [9:0] SKP_POS  = 10'h0c3;
  localparam int         TRAIN_N  = 16;
  localparam int         INTERVAL = 8;
  localparam int         BURST    = 2;

  typedef struct packed {
    logic [9:0] data;
    logic       skp;
    logic       train;
  } exp_t;

  logic       clk    = 1'b0;
  logic       arst_n = 1'b0;
  logic       start  = 1'b0;
  logic [9:0] tx_data;
  logic       training;
  logic       train_done;
  logic       skp_active;

  physical_tx_skp_inserter_if enc_if ();

  physical_tx_skp_inserter #(
    .TRAIN_CYCLES(TRAIN_N),
    .SKP_INTERVAL(INTERVAL),
    .SKP_BURST   (BURST)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .enc       (enc_if),
    .tx_data   (tx_data),
    .training  (training),
    .train_done(train_done),
    .skp_active(skp_active)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  exp_t       out_q[$];
  int         skp_left = 0;
  int         acc_cnt  = 0;
  logic       skp_form = 1'b0;
  logic [9:0] last_word = 10'h000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check();
    exp_t e;
    if (out_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_underrun got=empty expected=entry at %0t", $time);
    end else begin
      e = out_q.pop_front();
      check_val("tx_data", tx_data, e.data);
      check_val("skp_active", skp_active, e.skp);
      check_val("training", training, e.train);
      $display("tx %03h skp=%0b train=%0b", tx_data, skp_active, training);
    end
  endtask

  task automatic push_training();
    for (int k = 0; k < TRAIN_N; k++)
      out_q.push_back('{data: (k % 2) ? SKP_POS : SKP_NEG, skp: 1'b0, train: 1'b1});
  endtask

  // Runs the training window that a start edge in the current cycle launches.
  task automatic run_training(input logic drop_start);
    for (int k = 0; k < TRAIN_N; k++) begin
      tick();
      if (k == 0 && drop_start) start = 1'b0;
      pop_check();
      check_val("train_ready", enc_if.ready, 0);
      check_val("train_done_low", train_done, 0);
    end
    tick();
    check_val("done_ready", enc_if.ready, 1);
    check_val("done_flag", train_done, 1);
    check_val("done_training", training, 0);
    check_val("done_hold", tx_data, SKP_POS);
    skp_left  = 0;
    acc_cnt   = 0;
    last_word = SKP_POS;
  endtask

  task automatic data_cycle(input logic v, input logic [9:0] w, input logic r, output logic acc);
    exp_t e;
    enc_if.valid = v;
    enc_if.data  = w;
    enc_if.rd    = r;
    check_val("ready", enc_if.ready, skp_left == 0);
    acc = 1'b0;
    if (skp_left == 0) begin
      if (v) begin
        acc       = 1'b1;
        last_word = w;
        acc_cnt++;
        e = '{data: w, skp: 1'b0, train: 1'b0};
        if (acc_cnt == INTERVAL) begin
          skp_left = BURST;
          skp_form = r;
          acc_cnt  = 0;
        end
      end else begin
        e = '{data: last_word, skp: 1'b0, train: 1'b0};
        skp_left = BURST;
        skp_form = r;
        acc_cnt  = 0;
      end
    end else begin
      e = '{data: skp_form ? SKP_POS : SKP_NEG, skp: 1'b1, train: 1'b0};
      skp_form = ~skp_form;
      skp_left--;
    end
    out_q.push_back(e);
    tick();
    pop_check();
    check_val("train_done_hold", train_done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data"}, tx_data, 0);
    check_val({tag, "_ready"}, enc_if.ready, 0);
    check_val({tag, "_training"}, training, 0);
    check_val({tag, "_done"}, train_done, 0);
    check_val({tag, "_skp"}, skp_active, 0);
  endtask

  task automatic release_and_idle();
    arst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val("sync_hold", tx_data, 0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("idle_data", tx_data, (k % 2) ? SKP_POS : SKP_NEG);
      check_val("idle_ready", enc_if.ready, 0);
      check_val("idle_training", training, 0);
    end
  endtask

  initial begin
    logic [9:0] nw;
    logic       acc;
    enc_if.valid = 1'b0;
    enc_if.data  = 10'h000;
    enc_if.rd    = 1'b0;

    // Reset and IDLE alternation
    for (int k = 0; k < 3; k++) tick();
    check_reset_outputs("rst");
    release_and_idle();

    // Training from a start pulse
    start = 1'b1;
    push_training();
    run_training(1'b1);

    // Continuous data with scheduled bursts, encoder at RD+
    nw = 10'h001;
    while (nw <= 10'h010) begin
      data_cycle(1'b1, nw, 1'b1, acc);
      if (acc) nw = nw + 10'h001;
    end

    // Three words, then an underflow at RD-, then past the next scheduled burst
    while (nw <= 10'h013) begin
      data_cycle(1'b1, nw, 1'b0, acc);
      if (acc) nw = nw + 10'h001;
    end
    data_cycle(1'b0, 10'h2aa, 1'b0, acc);
    while (nw <= 10'h01d) begin
      data_cycle(1'b1, nw, 1'b1, acc);
      if (acc) nw = nw + 10'h001;
    end

    // Restart from data mode; start stays high afterwards
    start        = 1'b1;
    enc_if.valid = 1'b1;
    enc_if.data  = 10'h3aa;
    check_val("restart_ready", enc_if.ready, 1);
    out_q.delete();
    push_training();
    tick();
    enc_if.valid = 1'b0;
    pop_check();
    check_val("restart_done_low", train_done, 0);
    for (int k = 1; k < TRAIN_N; k++) begin
      tick();
      pop_check();
      check_val("retrain_ready", enc_if.ready, 0);
    end
    tick();
    check_val("retrain_done", train_done, 1);
    check_val("retrain_ready_hi", enc_if.ready, 1);
    skp_left  = 0;
    acc_cnt   = 0;
    last_word = SKP_POS;

    // Reset during the second word of a burst
    data_cycle(1'b1, 10'h101, 1'b1, acc);
    data_cycle(1'b1, 10'h102, 1'b1, acc);
    data_cycle(1'b0, 10'h103, 1'b1, acc);
    data_cycle(1'b1, 10'h103, 1'b1, acc);
    data_cycle(1'b1, 10'h103, 1'b1, acc);
    check_val("burst2_data", tx_data, SKP_NEG);
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    tick();
    check_reset_outputs("rst_held");
    release_and_idle();

    // A fresh start edge is needed after reset
    start = 1'b0;
    tick();
    check_val("idle_no_start", training, 0);
    start = 1'b1;
    tick();
    check_val("fresh_train", training, 1);
    check_val("fresh_data0", tx_data, SKP_NEG);
    tick();
    check_val("fresh_data1", tx_data, SKP_POS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
